// File: rtl/spi_apb_frontend_if.sv
// rtl/spi_apb_frontend_if.sv - APB3 register bus and SPI launch handshake bundle
//
// Purpose: groups the APB3 slave signals and the SPI-master launch handshake
//          so the front-end and its environment connect through one port.
// Modports:
//   slave  - the front-end: samples APB requests, returns PRDATA/PREADY/PSLVERR,
//            drives spi_data_valid/spi_wdata, samples spi_rdata/spi_rdy.
//   master - the environment: CPU-side APB requester plus the SPI master.
interface spi_apb_frontend_if #(
   parameter int WORD_LENGTH = 8
);
   logic                   PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [3:0]             PADDR;
   logic [31:0]            PWDATA;
   logic [31:0]            PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;
   logic                   spi_data_valid;
   logic [WORD_LENGTH-1:0] spi_wdata;
   logic [WORD_LENGTH-1:0] spi_rdata;
   logic                   spi_rdy;

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR,
      output spi_data_valid, spi_wdata,
      input  spi_rdata, spi_rdy
   );

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR,
      input  spi_data_valid, spi_wdata,
      output spi_rdata, spi_rdy
   );
endinterface

// File: rtl/spi_apb_frontend.sv
// rtl/spi_apb_frontend.sv - APB3 slave front-end with TX/RX FIFOs feeding an SPI master
//
// Purpose: buffers CPU words in a TX FIFO, launches one SPI transfer per word
//          through the data_valid / ready-busy handshake and stores each
//          received word in an RX FIFO. Registers (PADDR[3:2]):
//            0 TXDATA (W push), 1 RXDATA (R pop), 2 STATUS (R), 3 CTRL (R/W).
// Ports:
//   clk   - system / APB clock
//   rst_n - asynchronous active-low reset
//   bus   - spi_apb_frontend_if.slave: APB3 slave (zero wait state) and the
//           SPI launch handshake (spi_data_valid, spi_wdata, spi_rdata, spi_rdy)
//   irq   - registered interrupt: irq_en & (rx not empty | rx_ovf)
module spi_apb_frontend #(
   parameter int WORD_LENGTH = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_apb_frontend_if.slave     bus,
   output logic                  irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BSY  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                 state;

   logic [WORD_LENGTH-1:0] tx_mem [FIFO_DEPTH];
   logic [WORD_LENGTH-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]          tx_rd_ptr, tx_wr_ptr;
   logic [AW-1:0]          rx_rd_ptr, rx_wr_ptr;
   logic [CW-1:0]          tx_count, rx_count;

   logic                   ctrl_enable;
   logic                   ctrl_irq_en;
   logic                   rx_ovf;

   logic                   access;
   logic [1:0]             reg_sel;
   logic                   tx_empty, tx_full, rx_empty, rx_full;
   logic                   launch;
   logic                   tx_push, tx_pop;
   logic                   rx_done, rx_push, rx_pop;
   logic                   ovf_set, ctrl_wr;
   logic [31:0]            status;
   logic                   unused_bits;

   assign access   = bus.PSEL & bus.PENABLE;
   assign reg_sel  = bus.PADDR[3:2];

   // Flags come from the registered counts, i.e. their value at cycle start,
   // so a same-cycle pop/push never rescues a write-while-full or read-while-empty.
   assign tx_empty = (tx_count == '0);
   assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == CW'(FIFO_DEPTH));

   assign launch   = (state == IDLE) & ctrl_enable & ~tx_empty & bus.spi_rdy;
   assign tx_pop   = launch;
   assign tx_push  = access & bus.PWRITE & (reg_sel == 2'd0) & ~tx_full;

   // A completed transfer lands in RX unless RX is full, in which case the
   // word is dropped and the overflow sticky bit records the loss.
   assign rx_done  = (state == WAIT_DONE) & bus.spi_rdy;
   assign rx_push  = rx_done & ~rx_full;
   assign ovf_set  = rx_done & rx_full;
   assign rx_pop   = access & ~bus.PWRITE & (reg_sel == 2'd1) & ~rx_empty;

   assign ctrl_wr  = access & bus.PWRITE & (reg_sel == 2'd3);

   assign bus.PREADY = 1'b1;

   assign unused_bits = ^{bus.PADDR[1:0], bus.PWDATA[31:WORD_LENGTH]};

   // FIFO storage carries no reset; the pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= bus.PWDATA[WORD_LENGTH-1:0];
      if (rx_push) rx_mem[rx_wr_ptr] <= bus.spi_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_rd_ptr <= '0;
         tx_wr_ptr <= '0;
         tx_count  <= '0;
         rx_rd_ptr <= '0;
         rx_wr_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CW'(1);
            2'b01:   tx_count <= tx_count - CW'(1);
            default: ;
         endcase

         if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CW'(1);
            2'b01:   rx_count <= rx_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_enable <= 1'b0;
         ctrl_irq_en <= 1'b0;
         rx_ovf      <= 1'b0;
         irq         <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_enable <= bus.PWDATA[0];
            ctrl_irq_en <= bus.PWDATA[1];
         end
         // A new overflow beats a simultaneous software clear.
         if (ovf_set)
            rx_ovf <= 1'b1;
         else if (ctrl_wr & bus.PWDATA[2])
            rx_ovf <= 1'b0;
         irq <= ctrl_irq_en & (~rx_empty | rx_ovf);
      end
   end

   // Launch FSM. spi_wdata is only loaded on a launch, so it stays stable for
   // the whole transfer; spi_data_valid is high only in the cycle after launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         bus.spi_data_valid <= 1'b0;
         bus.spi_wdata      <= '0;
      end else begin
         bus.spi_data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  bus.spi_wdata      <= tx_mem[tx_rd_ptr];
                  bus.spi_data_valid <= 1'b1;
                  state              <= WAIT_BSY;
               end
            end
            WAIT_BSY: begin
               if (!bus.spi_rdy) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.spi_rdy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      status              = '0;
      status[0]           = tx_empty;
      status[1]           = tx_full;
      status[2]           = rx_empty;
      status[3]           = rx_full;
      status[4]           = (state != IDLE);
      status[5]           = rx_ovf;
      status[8 +: CW]     = tx_count;
      status[16 +: CW]    = rx_count;

      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      if (access) begin
         if (bus.PWRITE) begin
            case (reg_sel)
               2'd0:    bus.PSLVERR = tx_full;
               2'd1,
               2'd2:    bus.PSLVERR = 1'b1;
               default: ;
            endcase
         end else begin
            case (reg_sel)
               2'd1: begin
                  if (rx_empty)
                     bus.PSLVERR = 1'b1;
                  else
                     bus.PRDATA = 32'(rx_mem[rx_rd_ptr]);
               end
               2'd2:    bus.PRDATA = status;
               2'd3:    bus.PRDATA = {30'd0, ctrl_irq_en, ctrl_enable};
               default: ;
            endcase
         end
      end
   end
endmodule
